// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
package dmem_arb_pkg;

  // Who currently holds the data-memory bus.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  // address[18:16] value that selects the LED/button window.
  localparam logic [2:0] PERIPH_SEL_C = 3'b111;

  // Consecutive grants a locking DMA keeps while the CPU waits.
  localparam int DEFAULT_MAX_BURST = 4;

  // Width of a counter that must reach max_burst inclusive.
  function automatic int burst_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory manager.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // CPU load/store port
  logic              cpu_req_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_data_i;
  logic              cpu_wren_i;
  logic              cpu_gnt_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_rvalid_o;

  // Image DMA port
  logic              dma_req_i;
  logic              dma_lock_i;
  logic [ADDR_W-1:0] dma_addr_i;
  logic [DATA_W-1:0] dma_data_i;
  logic              dma_wren_i;
  logic              dma_gnt_o;
  logic [DATA_W-1:0] dma_rdata_o;
  logic              dma_rvalid_o;

  // Memory manager side
  logic [ADDR_W-1:0] mem_address_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_wren_o;
  logic [DATA_W-1:0] mem_data_i;

  // Peripheral write guard status
  logic              err_clr_i;
  logic              dma_err_o;

  modport slave (
    input  cpu_req_i, cpu_addr_i, cpu_data_i, cpu_wren_i,
    output cpu_gnt_o, cpu_rdata_o, cpu_rvalid_o,
    input  dma_req_i, dma_lock_i, dma_addr_i, dma_data_i, dma_wren_i,
    output dma_gnt_o, dma_rdata_o, dma_rvalid_o,
    output mem_address_o, mem_data_o, mem_wren_o,
    input  mem_data_i,
    input  err_clr_i,
    output dma_err_o
  );

  modport master (
    output cpu_req_i, cpu_addr_i, cpu_data_i, cpu_wren_i,
    input  cpu_gnt_o, cpu_rdata_o, cpu_rvalid_o,
    output dma_req_i, dma_lock_i, dma_addr_i, dma_data_i, dma_wren_i,
    input  dma_gnt_o, dma_rdata_o, dma_rvalid_o,
    input  mem_address_o, mem_data_o, mem_wren_o,
    output mem_data_i,
    output err_clr_i,
    input  dma_err_o
  );

endinterface

// File: rtl/dmem_arb_next_owner.sv
// Combinational next-owner and DMA burst-count decision.
// Only the DMA can lock; the CPU always yields to a pending DMA request.
module dmem_arb_next_owner
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int BURST_W   = burst_width(MAX_BURST)
) (
  input  owner_t             owner_i,
  input  owner_t             last_served_i,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               cpu_req_i,
  input  logic               dma_req_i,
  input  logic               dma_lock_i,
  output owner_t             owner_o,
  output logic [BURST_W-1:0] burst_o
);

  // A locking DMA may keep the bus only while this grant is not its last.
  logic dma_may_hold;
  assign dma_may_hold = dma_lock_i && ((int'(burst_i) + 1) < MAX_BURST);

  // Pick the next owner from the current requests and fairness history.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    owner_o = OWN_IDLE;
    if (cpu_req_i && dma_req_i) begin
      case (owner_i)
        OWN_CPU: owner_o = OWN_DMA;
        OWN_DMA: owner_o = dma_may_hold ? OWN_DMA : OWN_CPU;
        default: owner_o = (last_served_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
      endcase
    end else if (cpu_req_i) begin
      owner_o = OWN_CPU;
    end else if (dma_req_i) begin
      owner_o = OWN_DMA;
    end
  end

  // Count DMA grants within an unbroken DMA tenure, saturating at MAX_BURST.
  // Staying DMA implies dma_req_i is high, so the current cycle is a DMA grant.
  always_comb begin
    burst_o = '0;
    if (owner_i == OWN_DMA && owner_o == OWN_DMA) begin
      burst_o = (burst_i == BURST_W'(MAX_BURST)) ? burst_i : burst_i + BURST_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory/peripheral bus between the CPU
// load/store port and the image DMA. Grants are decoded from the owner
// register; read data is registered back to the winner; DMA writes into the
// peripheral window are suppressed and flagged.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter int         DATA_W     = 32,
  parameter int         MAX_BURST  = DEFAULT_MAX_BURST,
  parameter logic [2:0] PERIPH_SEL = PERIPH_SEL_C
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  localparam int BURST_W = burst_width(MAX_BURST);

  owner_t             owner_q, owner_d;
  owner_t             last_served_q, last_served_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic               cpu_rvalid_q, cpu_rvalid_d;
  logic               dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]  dma_rdata_q, dma_rdata_d;
  logic               dma_err_q, dma_err_d;

  logic               cpu_gnt;
  logic               dma_gnt;
  logic               dma_periph_wr;

  // Grants follow the registered owner, gated by the live request.
  assign cpu_gnt = (owner_q == OWN_CPU) && bus.cpu_req_i;
  assign dma_gnt = (owner_q == OWN_DMA) && bus.dma_req_i;

  // A granted DMA write aimed at the LED/button window.
  assign dma_periph_wr = dma_gnt && bus.dma_wren_i &&
                         (bus.dma_addr_i[18:16] == PERIPH_SEL);

  dmem_arb_next_owner #(
    .MAX_BURST (MAX_BURST),
    .BURST_W   (BURST_W)
  ) u_next_owner (
    .owner_i       (owner_q),
    .last_served_i (last_served_q),
    .burst_i       (burst_q),
    .cpu_req_i     (bus.cpu_req_i),
    .dma_req_i     (bus.dma_req_i),
    .dma_lock_i    (bus.dma_lock_i),
    .owner_o       (owner_d),
    .burst_o       (burst_d)
  );

  // Route the granted requester onto the memory bus; idle bus drives zeros.
  always_comb begin
    bus.mem_address_o = '0;
    bus.mem_data_o    = '0;
    bus.mem_wren_o    = 1'b0;
    if (cpu_gnt) begin
      bus.mem_address_o = bus.cpu_addr_i;
      bus.mem_data_o    = bus.cpu_data_i;
      bus.mem_wren_o    = bus.cpu_wren_i;
    end else if (dma_gnt) begin
      bus.mem_address_o = bus.dma_addr_i;
      bus.mem_data_o    = bus.dma_data_i;
      bus.mem_wren_o    = bus.dma_wren_i && !dma_periph_wr;
    end
  end

  // Next-state for fairness history, read return and the sticky error.
  always_comb begin
    last_served_d = last_served_q;
    if (cpu_gnt) begin
      last_served_d = OWN_CPU;
    end else if (dma_gnt) begin
      last_served_d = OWN_DMA;
    end

    cpu_rvalid_d = cpu_gnt && !bus.cpu_wren_i;
    dma_rvalid_d = dma_gnt && !bus.dma_wren_i;
    cpu_rdata_d  = cpu_rvalid_d ? bus.mem_data_i : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? bus.mem_data_i : dma_rdata_q;

    // Setting wins over a simultaneous clear.
    dma_err_d = dma_err_q;
    if (dma_periph_wr) begin
      dma_err_d = 1'b1;
    end else if (bus.err_clr_i) begin
      dma_err_d = 1'b0;
    end
  end

  // State registers; reset drops any access in flight.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q       <= OWN_IDLE;
      last_served_q <= OWN_DMA;
      burst_q       <= '0;
      cpu_rvalid_q  <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      dma_err_q     <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      burst_q       <= burst_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      dma_rvalid_q  <= dma_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      dma_err_q     <= dma_err_d;
    end
  end

  assign bus.cpu_gnt_o    = cpu_gnt;
  assign bus.dma_gnt_o    = dma_gnt;
  assign bus.cpu_rvalid_o = cpu_rvalid_q;
  assign bus.dma_rvalid_o = dma_rvalid_q;
  assign bus.cpu_rdata_o  = cpu_rdata_q;
  assign bus.dma_rdata_o  = dma_rdata_q;
  assign bus.dma_err_o    = dma_err_q;

endmodule
